cpu_run_ctrl: RTL
=================

// Module: cpu_run_ctrl
// PURPOSE
//  Board-level run/step controller in front of the single-cycle CPU core. It converts run/step/valid
//  switches into a per-cycle CPU clock enable and stalls the core on input instructions until valid.
//  It also latches CPU output and time-multiplexes a selected 32-bit value onto 8 hex digits (an/seg).
// PARAMETERS
//  SCAN_W   16  width of digit-scan prescaler; digit advances every 2**(SCAN_W-3) clk (sim: 3)
//  DATA_W   32  width of pc / io_out_data / dbg_data
// PORTS
//  clk          in   1       system clock, sole clock domain
//  rst          in   1       synchronous reset, active-high
//  run          in   1       level: 1 = free-run CPU
//  step         in   1       single-step button (async level)
//  valid        in   1       input-confirm / display-mode button (async level)
//  in           in   5       switches: input data / debug address
//  io_in_req    in   1       CPU current instr is an input read (combinational from core)
//  io_out_we    in   1       CPU current instr writes output port
//  io_out_data  in   DATA_W  CPU output value
//  pc           in   DATA_W  CPU current PC
//  dbg_data     in   DATA_W  register/memory read data at dbg_addr
//  cpu_en       out  1       CPU state-commit enable for this clk
//  io_in_data   out  5       latched input value presented to CPU
//  io_in_ack    out  1       1-cycle pulse: io_in_data valid, CPU commits input instr
//  dbg_addr     out  5       = in, registered
//  check        out  2       display-mode indicator (LED6-5)
//  out0         out  5       LED4-0: registered copy of in
//  an           out  3       active digit index 0..7
//  seg          out  4       hex nibble of active digit
//  ready        out  1       1 = waiting for valid to supply input
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): state=HALT; cpu_en=0, io_in_ack=0, ready=0, check=2'b00, out0=0,
//   dbg_addr=0, io_in_data=0, out_reg=0, scan counter=0 (an=0). Edge-sync history cleared to 0.
//  step/valid: 2-FF synchronizer + rising-edge detect -> step_p/valid_p 1-cycle pulses,
//   2 clk latency from pin; a high held across cycles yields exactly one pulse.
//  FSM states: HALT, RUN, STEP, WAIT_IN (registered).
//   HALT: run=1 -> RUN (run wins over simultaneous step_p); else step_p -> STEP; else stay.
//   RUN:  run=0 -> HALT; io_in_req=1 -> WAIT_IN; else stay.
//   STEP: io_in_req=1 -> WAIT_IN; else -> HALT (exactly one committed instr).
//   WAIT_IN: valid_p -> (run ? RUN : HALT); else stay. run/step ignored while waiting.
//  cpu_en (comb): 1 when (RUN|STEP) && !io_in_req, or WAIT_IN && valid_p; else 0.
//  io_in_ack = WAIT_IN && valid_p; io_in_data = in sampled at that valid_p (registered, holds).
//  ready = (state==WAIT_IN), registered with state.
//  step_p in RUN/STEP/WAIT_IN dropped. valid_p in HALT advances check 00->01->10->11->00;
//   valid_p in RUN/STEP ignored.
//  out_reg <= io_out_data when io_out_we && cpu_en; else hold.
//  Display value: check 00 out_reg, 01 {zero-ext io_in_data}, 10 pc, 11 dbg_data.
//  Scan: SCAN_W-bit free counter, an = top 3 bits (wraps 7->0); seg = value[4*an+3:4*an].
//  dbg_addr, out0 <= in every clk (1-cycle latency).
//  rst mid-WAIT_IN or mid-STEP: no ack/enable issued that cycle; FSM to HALT.
// STRUCTURE
//  Package cpu_ctrl_pkg: FSM state encoding (HALT=0,RUN=1,STEP=2,WAIT_IN=3); CHK_OUT/CHK_IN/CHK_PC/CHK_DBG.
//  Sub-module btn_edge_sync (2-FF sync + rise pulse), instanced twice (step, valid).
// TESTING
//  1 rst=1 2 clk, release, run=0 -> cpu_en=0, check=00, an counts 0..7 and wraps.
//  2 HALT, step 0->1 held 5 clk -> exactly one cpu_en pulse, 3 clk after pin rise; state back to HALT.
//  3 run=1 -> cpu_en=1 every clk; run=0 -> cpu_en=0 from next clk; step toggling each clk while
//    running never adds cycles.
//  4 RUN, io_in_req=1, in=5'h15 -> ready=1, cpu_en=0; valid rise -> one clk io_in_ack=1, cpu_en=1,
//    io_in_data=5'h15; return to RUN, ready=0.
//  5 HALT, four valid pulses -> check 01,10,11,00; with pc=32'h0000_1234, check=10: an=0 seg=4, an=3 seg=1.
//  6 io_out_we=1, io_out_data=32'hDEAD_BEEF, cpu_en=1 -> out_reg updates, an=7 seg=D; rst during
//    WAIT_IN -> HALT, ready=0, no ack.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run/step controller: FSM states, display modes
// and the hex-digit extraction helper.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT    = 2'd0,
    RUN     = 2'd1,
    STEP    = 2'd2,
    WAIT_IN = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    CHK_OUT = 2'd0,
    CHK_IN  = 2'd1,
    CHK_PC  = 2'd2,
    CHK_DBG = 2'd3
  } chk_mode_e;

  localparam int DISP_W = 32;

  function automatic logic [3:0] hex_nibble(input logic [DISP_W-1:0] value, input logic [2:0] idx);
    return value[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Handshake bundle between the CPU core (master) and the run/step controller (slave).
interface cpu_run_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              io_in_req;
  logic              io_out_we;
  logic [DATA_W-1:0] io_out_data;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] dbg_data;
  logic              cpu_en;
  logic [4:0]        io_in_data;
  logic              io_in_ack;
  logic [4:0]        dbg_addr;

  modport master (
    output io_in_req, io_out_we, io_out_data, pc, dbg_data,
    input  cpu_en, io_in_data, io_in_ack, dbg_addr
  );

  modport slave (
    input  io_in_req, io_out_we, io_out_data, pc, dbg_data,
    output cpu_en, io_in_data, io_in_ack, dbg_addr
  );
endinterface

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for an asynchronous button plus a rising-edge pulse;
// a held button yields one pulse two clocks after the pin rises.
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  logic [2:0] hist_r;

  // hist_r[0] is the newest sample; [1] is the synchronized level, [2] its previous value
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_r <= 3'b000;
    end else begin
      hist_r <= {hist_r[1:0], btn};
    end
  end

  assign pulse = hist_r[1] & ~hist_r[2];
endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller: turns run/step/valid switches into a per-cycle CPU enable,
// stalls on input instructions until valid, and scans a selected value onto 8 hex digits.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int SCAN_W = 16,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          step,
  input  logic          valid,
  input  logic [4:0]    in,
  cpu_run_ctrl_if.slave core,
  output logic [1:0]    check,
  output logic [4:0]    out0,
  output logic [2:0]    an,
  output logic [3:0]    seg,
  output logic          ready
);
  logic              step_p_s;
  logic              valid_p_s;
  run_state_e        state_r;
  run_state_e        state_s;
  logic              cpu_en_s;
  logic              ack_s;
  chk_mode_e         check_r;
  logic [4:0]        io_in_data_r;
  logic [DATA_W-1:0] out_reg_r;
  logic [4:0]        out0_r;
  logic [4:0]        dbg_addr_r;
  logic [SCAN_W-1:0] scan_r;
  logic              ready_r;
  logic [DISP_W-1:0] disp_s;

  btn_edge_sync u_step_sync (.clk(clk), .rst(rst), .btn(step), .pulse(step_p_s));
  btn_edge_sync u_valid_sync (.clk(clk), .rst(rst), .btn(valid), .pulse(valid_p_s));

  // Next-state logic; run has priority over a simultaneous step pulse in HALT
  always_comb begin
    state_s = state_r;
    case (state_r)
      HALT: begin
        if (run) state_s = RUN;
        else if (step_p_s) state_s = STEP;
        else state_s = HALT;
      end
      RUN: begin
        if (!run) state_s = HALT;
        else if (core.io_in_req) state_s = WAIT_IN;
        else state_s = RUN;
      end
      STEP: begin
        if (core.io_in_req) state_s = WAIT_IN;
        else state_s = HALT;
      end
      WAIT_IN: begin
        if (valid_p_s) state_s = run ? RUN : HALT;
        else state_s = WAIT_IN;
      end
      default: state_s = HALT;
    endcase
  end

  // Commit enable and input acknowledge, suppressed while reset is asserted
  always_comb begin
    cpu_en_s = 1'b0;
    ack_s    = 1'b0;
    if (rst) begin
      cpu_en_s = 1'b0;
      ack_s    = 1'b0;
    end else if (state_r == WAIT_IN) begin
      cpu_en_s = valid_p_s;
      ack_s    = valid_p_s;
    end else if ((state_r == RUN) || (state_r == STEP)) begin
      cpu_en_s = ~core.io_in_req;
      ack_s    = 1'b0;
    end else begin
      cpu_en_s = 1'b0;
      ack_s    = 1'b0;
    end
  end

  // State, display mode, latched I/O values and the digit-scan counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= HALT;
      ready_r      <= 1'b0;
      check_r      <= CHK_OUT;
      io_in_data_r <= 5'd0;
      out_reg_r    <= {DATA_W{1'b0}};
      out0_r       <= 5'd0;
      dbg_addr_r   <= 5'd0;
      scan_r       <= {SCAN_W{1'b0}};
    end else begin
      state_r    <= state_s;
      ready_r    <= (state_s == WAIT_IN);
      out0_r     <= in;
      dbg_addr_r <= in;
      scan_r     <= scan_r + SCAN_W'(1);
      if ((state_r == HALT) && valid_p_s) check_r <= chk_mode_e'(check_r + 2'd1);
      if (ack_s) io_in_data_r <= in;
      if (core.io_out_we && cpu_en_s) out_reg_r <= core.io_out_data;
    end
  end

  // Display source selection
  always_comb begin
    disp_s = 32'h0;
    case (check_r)
      CHK_OUT: disp_s = out_reg_r;
      CHK_IN:  disp_s = {{(DISP_W-5){1'b0}}, io_in_data_r};
      CHK_PC:  disp_s = core.pc;
      CHK_DBG: disp_s = core.dbg_data;
      default: disp_s = 32'h0;
    endcase
  end

  assign an              = scan_r[SCAN_W-1 -: 3];
  assign seg             = hex_nibble(disp_s, an);
  assign check           = check_r;
  assign out0            = out0_r;
  assign ready           = ready_r;
  assign core.cpu_en     = cpu_en_s;
  assign core.io_in_ack  = ack_s;
  assign core.io_in_data = io_in_data_r;
  assign core.dbg_addr   = dbg_addr_r;
endmodule
